ram_port_arbiter: RTL and testbench

Two-client arbiter that shares the team's dual-port RAM (one write port, one read port) between two requesters. Each client issues one read or write command per cycle. Reads and writes are arbitrated independently, so a read from one client and a write from the other both issue in the same cycle. Read data is steered back to the requesting client with a per-client valid strobe. The block sits between the client logic and the RAM ports and drives all RAM control inputs.

---
 rtl/ram_port_arbiter_if.sv | 54 +++++
 rtl/ram_port_arbiter.sv | 113 +++++++++++
 tb/tb_ram_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_if.sv
// Client and RAM-side bus of the two-client RAM port arbiter.
// slave: arbiter side; master: clients plus RAM (bench side).
interface ram_port_arbiter_if #(
   parameter int WIDTH   = 16,
   parameter int ADDRESS = 5
);
   logic               i_c0_req;
   logic               i_c0_we;
   logic [ADDRESS-1:0] i_c0_addr;
   logic [WIDTH-1:0]   i_c0_wdata;
   logic               i_c1_req;
   logic               i_c1_we;
   logic [ADDRESS-1:0] i_c1_addr;
   logic [WIDTH-1:0]   i_c1_wdata;
   logic               o_c0_gnt;
   logic               o_c1_gnt;
   logic               o_c0_rvalid;
   logic               o_c1_rvalid;
   logic [WIDTH-1:0]   o_c0_rdata;
   logic [WIDTH-1:0]   o_c1_rdata;
   logic               o_ram_cs;
   logic               o_ram_valid;
   logic               o_ram_wr_en;
   logic [ADDRESS-1:0] o_ram_wr_addr;
   logic [WIDTH-1:0]   o_ram_wr_data;
   logic               o_ram_rd_en;
   logic [ADDRESS-1:0] o_ram_rd_addr;
   logic [WIDTH-1:0]   i_ram_rd_data;
   logic               i_ram_ready;

   modport slave (
      input  i_c0_req, i_c0_we, i_c0_addr, i_c0_wdata,
      input  i_c1_req, i_c1_we, i_c1_addr, i_c1_wdata,
      input  i_ram_rd_data, i_ram_ready,
      output o_c0_gnt, o_c1_gnt,
      output o_c0_rvalid, o_c1_rvalid,
      output o_c0_rdata, o_c1_rdata,
      output o_ram_cs, o_ram_valid, o_ram_wr_en,
      output o_ram_wr_addr, o_ram_wr_data,
      output o_ram_rd_en, o_ram_rd_addr
   );

   modport master (
      output i_c0_req, i_c0_we, i_c0_addr, i_c0_wdata,
      output i_c1_req, i_c1_we, i_c1_addr, i_c1_wdata,
      output i_ram_rd_data, i_ram_ready,
      input  o_c0_gnt, o_c1_gnt,
      input  o_c0_rvalid, o_c1_rvalid,
      input  o_c0_rdata, o_c1_rdata,
      input  o_ram_cs, o_ram_valid, o_ram_wr_en,
      input  o_ram_wr_addr, o_ram_wr_data,
      input  o_ram_rd_en, o_ram_rd_addr
   );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter for a 1W/1R RAM; reads and writes arbitrate separately.
// Ports: i_clk, i_rst (sync, active high), bus (ram_port_arbiter_if.slave).
// ARB_ROUND_ROBIN_EN: round-robin on contention; undefined = c0 always wins.
module ram_port_arbiter #(
   parameter int WIDTH   = 16,
   parameter int ADDRESS = 5
) (
   input  logic i_clk,
   input  logic i_rst,
   ram_port_arbiter_if.slave bus
);
   logic wr_c0, wr_c1, rd_c0, rd_c1;
   logic wr_g0, wr_g1, rd_g0, rd_g1;
   logic wr_acc, rd_acc;

   logic               wr_q;
   logic [ADDRESS-1:0] wr_addr_q;
   logic [WIDTH-1:0]   wr_data_q;
   logic               rd_q;
   logic               rd_tag_q;
   logic [ADDRESS-1:0] rd_addr_q;
   logic               ret_q;
   logic               ret_tag_q;
   logic [WIDTH-1:0]   hold0_q;
   logic [WIDTH-1:0]   hold1_q;
   logic               rv0, rv1;

   assign wr_c0 = bus.i_c0_req & bus.i_c0_we;
   assign wr_c1 = bus.i_c1_req & bus.i_c1_we;
   assign rd_c0 = bus.i_c0_req & ~bus.i_c0_we;
   assign rd_c1 = bus.i_c1_req & ~bus.i_c1_we;

`ifdef ARB_ROUND_ROBIN_EN
   // Pointer names the winner of the next contested grant.
   logic wr_ptr, rd_ptr;

   assign wr_g0 = bus.i_ram_ready & wr_c0 & (~wr_c1 | ~wr_ptr);
   assign wr_g1 = bus.i_ram_ready & wr_c1 & (~wr_c0 | wr_ptr);
   assign rd_g0 = rd_c0 & (~rd_c1 | ~rd_ptr);
   assign rd_g1 = rd_c1 & (~rd_c0 | rd_ptr);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (bus.i_ram_ready & wr_c0 & wr_c1)
            wr_ptr <= ~wr_ptr;
         if (rd_c0 & rd_c1)
            rd_ptr <= ~rd_ptr;
      end
   end
`else
   assign wr_g0 = bus.i_ram_ready & wr_c0;
   assign wr_g1 = bus.i_ram_ready & wr_c1 & ~wr_c0;
   assign rd_g0 = rd_c0;
   assign rd_g1 = rd_c1 & ~rd_c0;
`endif

   assign wr_acc = wr_g0 | wr_g1;
   assign rd_acc = rd_g0 | rd_g1;

   assign bus.o_c0_gnt = wr_g0 | rd_g0;
   assign bus.o_c1_gnt = wr_g1 | rd_g1;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_q      <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_q      <= 1'b0;
         rd_tag_q  <= 1'b0;
         rd_addr_q <= '0;
         ret_q     <= 1'b0;
         ret_tag_q <= 1'b0;
         hold0_q   <= '0;
         hold1_q   <= '0;
      end else begin
         wr_q <= wr_acc;
         if (wr_acc) begin
            wr_addr_q <= wr_g1 ? bus.i_c1_addr : bus.i_c0_addr;
            wr_data_q <= wr_g1 ? bus.i_c1_wdata : bus.i_c0_wdata;
         end
         rd_q     <= rd_acc;
         rd_tag_q <= rd_g1;
         if (rd_acc)
            rd_addr_q <= rd_g1 ? bus.i_c1_addr : bus.i_c0_addr;
         ret_q     <= rd_q;
         ret_tag_q <= rd_tag_q;
         if (rv0)
            hold0_q <= bus.i_ram_rd_data;
         if (rv1)
            hold1_q <= bus.i_ram_rd_data;
      end
   end

   assign bus.o_ram_cs      = wr_q;
   assign bus.o_ram_valid   = wr_q;
   assign bus.o_ram_wr_en   = wr_q;
   assign bus.o_ram_wr_addr = wr_addr_q;
   assign bus.o_ram_wr_data = wr_data_q;
   assign bus.o_ram_rd_en   = rd_q;
   assign bus.o_ram_rd_addr = rd_addr_q;

   // RAM output is already registered, so the strobe cycle passes it
   // straight through and the hold register keeps it afterwards.
   assign rv0 = ret_q & ~ret_tag_q;
   assign rv1 = ret_q & ret_tag_q;
   assign bus.o_c0_rvalid = rv0;
   assign bus.o_c1_rvalid = rv1;
   assign bus.o_c0_rdata  = rv0 ? bus.i_ram_rd_data : hold0_q;
   assign bus.o_c1_rdata  = rv1 ? bus.i_ram_rd_data : hold1_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter.
// Holds a behavioural RAM and a reference model of arbitration and reads.
module tb_ram_port_arbiter;
   localparam int W = 16;
   localparam int A = 5;
   localparam int D = 1 << A;

   logic i_clk = 1'b0;
   logic i_rst;
   always #5 i_clk = ~i_clk;

   ram_port_arbiter_if #(.WIDTH(W), .ADDRESS(A)) bus ();

   ram_port_arbiter #(.WIDTH(W), .ADDRESS(A)) dut (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .bus  (bus)
   );

   // Behavioural RAM: registered read, read-before-write.
   logic [W-1:0] ram [D];
   logic [W-1:0] ram_q = '0;
   logic         ram_init = 1'b0;
   assign bus.i_ram_rd_data = ram_q;

   always @(posedge i_clk) begin
      if (!ram_init) begin
         for (int i = 0; i < D; i++) ram[i] <= W'(i);
         ram_init <= 1'b1;
      end else begin
         if (bus.o_ram_rd_en) ram_q <= ram[bus.o_ram_rd_addr];
         if (bus.o_ram_cs && bus.o_ram_valid && bus.o_ram_wr_en)
            ram[bus.o_ram_wr_addr] <= bus.o_ram_wr_data;
      end
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference model state
   typedef struct {
      int          due;
      bit          cl;
      logic [W-1:0] d;
   } exp_t;

   exp_t         exp_q[$];
   logic [W-1:0] ref_mem [D];
   logic [W-1:0] m_rdata [2];
   bit           m_wr_ptr, m_rd_ptr;
   bit           m_wv, m_rv;
   logic [A-1:0] m_wa, m_ra;
   logic [W-1:0] m_wd;
   int           cyc;

   bit           obs_g0, obs_g1, obs_rv0;
   logic [W-1:0] obs_rd0;

   task automatic drive(bit q0, bit w0, int a0, int d0,
                        bit q1, bit w1, int a1, int d1);
      bus.i_c0_req   = q0;
      bus.i_c0_we    = w0;
      bus.i_c0_addr  = A'(a0);
      bus.i_c0_wdata = W'(d0);
      bus.i_c1_req   = q1;
      bus.i_c1_we    = w1;
      bus.i_c1_addr  = A'(a1);
      bus.i_c1_wdata = W'(d1);
   endtask

   task automatic step();
      bit   wc0, wc1, rc0, rc1;
      bit   wg0, wg1, rg0, rg1;
      bit   ev0, ev1;
      exp_t e;
      @(negedge i_clk);
      wc0 = bus.i_c0_req && bus.i_c0_we;
      wc1 = bus.i_c1_req && bus.i_c1_we;
      rc0 = bus.i_c0_req && !bus.i_c0_we;
      rc1 = bus.i_c1_req && !bus.i_c1_we;
      wg0 = 0; wg1 = 0; rg0 = 0; rg1 = 0;
      if (bus.i_ram_ready) begin
         if (wc0 && wc1) begin
            if (m_wr_ptr) wg1 = 1; else wg0 = 1;
         end else begin
            wg0 = wc0; wg1 = wc1;
         end
      end
      if (rc0 && rc1) begin
         if (m_rd_ptr) rg1 = 1; else rg0 = 1;
      end else begin
         rg0 = rc0; rg1 = rc1;
      end
      obs_g0  = bus.o_c0_gnt;
      obs_g1  = bus.o_c1_gnt;
      obs_rv0 = bus.o_c0_rvalid;
      obs_rd0 = bus.o_c0_rdata;
      check("gnt0", 32'(bus.o_c0_gnt), 32'(wg0 | rg0));
      check("gnt1", 32'(bus.o_c1_gnt), 32'(wg1 | rg1));
      ev0 = 0; ev1 = 0;
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
         e = exp_q.pop_front();
         if (e.cl) ev1 = 1; else ev0 = 1;
         m_rdata[e.cl] = e.d;
      end
      check("rvalid0", 32'(bus.o_c0_rvalid), 32'(ev0));
      check("rvalid1", 32'(bus.o_c1_rvalid), 32'(ev1));
      check("rdata0", 32'(bus.o_c0_rdata), 32'(m_rdata[0]));
      check("rdata1", 32'(bus.o_c1_rdata), 32'(m_rdata[1]));
      check("ram_wr_en", 32'(bus.o_ram_wr_en), 32'(m_wv));
      check("ram_cs", 32'(bus.o_ram_cs), 32'(m_wv));
      check("ram_valid", 32'(bus.o_ram_valid), 32'(m_wv));
      check("ram_rd_en", 32'(bus.o_ram_rd_en), 32'(m_rv));
      if (m_wv) begin
         check("ram_wr_addr", 32'(bus.o_ram_wr_addr), 32'(m_wa));
         check("ram_wr_data", 32'(bus.o_ram_wr_data), 32'(m_wd));
      end
      if (m_rv)
         check("ram_rd_addr", 32'(bus.o_ram_rd_addr), 32'(m_ra));
      @(posedge i_clk);
      #1;
      if (i_rst) begin
         m_wv = 0; m_rv = 0;
         m_wr_ptr = 0; m_rd_ptr = 0;
         m_rdata[0] = '0; m_rdata[1] = '0;
         exp_q.delete();
      end else begin
         m_rv = rg0 | rg1;
         if (m_rv) begin
            m_ra = rg1 ? bus.i_c1_addr : bus.i_c0_addr;
            exp_q.push_back('{cyc + 2, rg1, ref_mem[m_ra]});
         end
         m_wv = wg0 | wg1;
         if (m_wv) begin
            m_wa = wg1 ? bus.i_c1_addr : bus.i_c0_addr;
            m_wd = wg1 ? bus.i_c1_wdata : bus.i_c0_wdata;
            ref_mem[m_wa] = m_wd;
         end
`ifdef ARB_ROUND_ROBIN_EN
         if (bus.i_ram_ready && wc0 && wc1) m_wr_ptr = !m_wr_ptr;
         if (rc0 && rc1) m_rd_ptr = !m_rd_ptr;
`endif
      end
      cyc++;
   endtask

   initial begin
      for (int i = 0; i < D; i++) ref_mem[i] = W'(i);
      m_rdata[0] = '0; m_rdata[1] = '0;
      m_wr_ptr = 0; m_rd_ptr = 0;
      m_wv = 0; m_rv = 0;
      m_wa = '0; m_ra = '0; m_wd = '0;
      cyc = 0;
      i_rst = 1'b1;
      bus.i_ram_ready = 1'b1;

      // Reset with both clients requesting writes
      drive(1, 1, 3, 16'h1111, 1, 1, 4, 16'h2222);
      repeat (3) step();
      check("rst_rdata0", 32'(obs_rd0), 32'h0);
      check("rst_rvalid0", 32'(obs_rv0), 32'h0);
      i_rst = 1'b0;

      // Contested writes held three cycles
      step();
      check("first_wr_c0", 32'(obs_g0), 32'h1);
      check("first_wr_c1", 32'(obs_g1), 32'h0);
      step();
`ifdef ARB_ROUND_ROBIN_EN
      check("second_wr_c1", 32'(obs_g1), 32'h1);
`else
      check("second_wr_c0", 32'(obs_g0), 32'h1);
`endif
      step();
      drive(0, 0, 0, 0, 1, 1, 4, 16'h2222);
      step();

      // Mixed: c0 reads addr 3, c1 writes addr 7
      drive(1, 0, 3, 0, 1, 1, 7, 16'h7777);
      step();
      check("mixed_g0", 32'(obs_g0), 32'h1);
      check("mixed_g1", 32'(obs_g1), 32'h1);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      check("mixed_rv0", 32'(obs_rv0), 32'h1);
      check("mixed_rd0", 32'(obs_rd0), 32'h1111);

      // Read during write at addr 5
      drive(1, 0, 5, 0, 1, 1, 5, 16'hBEEF);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      check("rdw_old", 32'(obs_rd0), 32'h0005);
      drive(1, 0, 5, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      step();
      check("rdw_new", 32'(obs_rd0), 32'hBEEF);

      // Back-to-back contested reads
      for (int i = 0; i < 8; i++) begin
         drive(1, 0, i, 0, 1, 0, i + 8, 0);
         step();
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();

      // Reset one cycle after an accepted read
      drive(1, 0, 3, 0, 0, 0, 0, 0);
      step();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      i_rst = 1'b1;
      step();
      i_rst = 1'b0;
      step();
      check("rst_drop_rv0", 32'(obs_rv0), 32'h0);
      step();

      // RAM not ready: writes stall, reads proceed
      bus.i_ram_ready = 1'b0;
      drive(1, 1, 9, 16'h9999, 1, 0, 3, 0);
      step();
      check("stall_wr_g0", 32'(obs_g0), 32'h0);
      check("stall_rd_g1", 32'(obs_g1), 32'h1);
      step();
      bus.i_ram_ready = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) step();

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
               bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
               int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
         bus.i_ram_ready = ($urandom_range(0, 4) != 0);
         i_rst = ($urandom_range(0, 49) == 0);
         step();
      end
      i_rst = 1'b0;
      bus.i_ram_ready = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end
endmodule
